load_store_buffer: RTL
======================

LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 Parameters, one per line:
  LSB_CAPACITY, 8, entry count, power of two.
  TAG_W, 4, ROB tag width; tag 0 is the null tag.
REQ-002 Ports, one per line:
  clk  in  1  clock, all state on rising edge
  rst  in  1  reset, synchronous, active-high
  rollback_in  in  1  flush speculative state
  full_out  out  1  queue cannot accept an issue
  dec_issue_in  in  1  new entry valid
  dec_is_store_in  in  1  1 = store, 0 = load
  dec_funct3_in  in  3  access size and signedness
  dec_Qj_in/dec_Qk_in  in  TAG_W  base/data producer tags
  dec_Vj_in/dec_Vk_in  in  32  base/data values, valid when Q = 0
  dec_imm_in  in  32  address offset
  dec_dest_tag_in  in  TAG_W  ROB tag of this entry
  alu_broadcast_signal_in, alu_result_in[32], alu_dest_tag_in[TAG_W]  in  ALU CDB
  rob_broadcast_signal_in, rob_result_in[32], rob_dest_tag_in[TAG_W]  in  ROB commit CDB
  commit_lsb_signal_in  in  1  ROB commits a store
  commit_tag_in  in  TAG_W  tag of the committed store
  mem_req_out  out  1  memory request, held until done
  mem_we_out  out  1  1 = write
  mem_addr_out  out  32  byte address
  mem_data_out  out  32  store data, right-aligned
  mem_size_out  out  2  0 = byte, 1 = half, 2 = word
  mem_done_in  in  1  one-cycle completion pulse
  mem_data_in  in  32  raw load data, right-aligned, valid with done
  broadcast_signal_out  out  1  load result valid, one-cycle pulse
  result_out  out  32  extended load data
  dest_tag_out  out  TAG_W  ROB tag of the load

Function
REQ-003 Circular queue: head, tail, and count of width log2(LSB_CAPACITY)+1; pointers wrap from LSB_CAPACITY-1 to 0.
REQ-004 full_out = (count == LSB_CAPACITY), combinational.
REQ-005 Issue with !full_out writes the entry at tail, advances tail, and sets committed = 0.
REQ-006 Issue and head pop in the same cycle are both performed; count is unchanged.
REQ-007 Snoop: any valid entry with Qj (or Qk) equal to a nonzero broadcasting tag takes V from that bus and clears Q to 0.
REQ-008 If both buses match, the ALU bus wins.
REQ-009 Issue bypass: when dec_Qj_in/dec_Qk_in matches a same-cycle broadcast, the entry is stored with Q = 0 and the broadcast value.
REQ-010 commit_lsb_signal_in sets committed on the valid store entry whose dest_tag equals commit_tag_in.
REQ-011 FSM IDLE, IDLE -> WAIT_MEM: only the head entry executes, and only when count != 0 and Qj == 0.
  Load: no further condition.
  Store: also requires Qk == 0 and committed == 1.
REQ-012 Transition outputs on the IDLE -> WAIT_MEM edge:
  mem_req_out = 1
  mem_addr_out = Vj + imm, modulo 2^32
  mem_we_out = is_store
  mem_size_out = funct3[1:0]
  mem_data_out = Vk
REQ-013 WAIT_MEM holds all mem_* outputs stable until mem_done_in.
REQ-014 On mem_done_in: mem_req_out drops next edge, head pops, FSM returns to IDLE.
REQ-015 A new request may start no earlier than the cycle after mem_done_in.
REQ-016 Load completion:
  Next edge: broadcast_signal_out = 1 and dest_tag_out = head tag.
  funct3 000 -> sign-extend byte; 001 -> sign-extend half; 010 -> word; 100 -> zero-extend byte; 101 -> zero-extend half.
REQ-017 Store completion produces no broadcast.
REQ-018 Rollback, applied on the edge where rollback_in = 1:
  Every uncommitted entry is discarded.
  Committed stores are kept; they are always the oldest contiguous run from head.
  tail moves to just past the last committed store; count is updated to match.
  Issue and commit in that cycle are ignored.
REQ-019 Rollback while WAIT_MEM with a store in flight: the access completes normally.
REQ-020 Rollback while WAIT_MEM with a load in flight:
  Hold the request until mem_done_in, then return to IDLE.
  No broadcast; no head pop, since the entry is already gone.
REQ-021 Loads never bypass older stores; ordering is strictly head-first.

Reset
REQ-022 On rst:
  Outputs: mem_req_out, mem_we_out, broadcast_signal_out = 0; mem_addr_out, mem_data_out, result_out = 0; mem_size_out = 0; dest_tag_out = 0.
  State: head = tail = count = 0; all entries invalid; FSM IDLE.
REQ-023 rst overrides rollback_in and any in-flight access; a mem_done_in in the first cycle after reset is ignored.

Verification
REQ-024 LB, Vj=0x100, imm=4, mem_data_in=0x80 after 3 cycles -> addr 0x104, size 0; broadcast result 0xFFFFFF80 with the entry tag.
REQ-025 SW tag 3, Qk=5; ALU broadcasts tag 5 = 0xDEAD; then commit tag 3 -> mem_req with we=1, data 0xDEAD, size 2; no broadcast.
REQ-026 Eight issues with no pop -> full_out = 1; a ninth dec_issue_in leaves count at 8; one pop plus issue in one cycle -> count stays 8; pointers wrap 7 -> 0.
REQ-027 Queue: committed SW, uncommitted SB, LW; assert rollback -> count 1; SW still executes; SB and LW never reach memory.
REQ-028 Rollback during an in-flight LH -> mem_req held until done; no broadcast; FSM IDLE; the next issued entry executes.
REQ-029 Issue with dec_Qj_in = 7 while ALU broadcasts tag 7 = 0x200 -> the entry executes with address 0x200 + imm.

Source files
------------

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue with CDB snooping, commit tracking and rollback.
// Rev 1.0 -- single outstanding memory access, issued strictly from the head.
`default_nettype none

module load_store_buffer #(
  parameter int LSB_CAPACITY = 8,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rollback_in,
  output logic             full_out,
  input  logic             dec_issue_in,
  input  logic             dec_is_store_in,
  input  logic [2:0]       dec_funct3_in,
  input  logic [TAG_W-1:0] dec_Qj_in,
  input  logic [TAG_W-1:0] dec_Qk_in,
  input  logic [31:0]      dec_Vj_in,
  input  logic [31:0]      dec_Vk_in,
  input  logic [31:0]      dec_imm_in,
  input  logic [TAG_W-1:0] dec_dest_tag_in,
  input  logic             alu_broadcast_signal_in,
  input  logic [31:0]      alu_result_in,
  input  logic [TAG_W-1:0] alu_dest_tag_in,
  input  logic             rob_broadcast_signal_in,
  input  logic [31:0]      rob_result_in,
  input  logic [TAG_W-1:0] rob_dest_tag_in,
  input  logic             commit_lsb_signal_in,
  input  logic [TAG_W-1:0] commit_tag_in,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic [31:0]      mem_addr_out,
  output logic [31:0]      mem_data_out,
  output logic [1:0]       mem_size_out,
  input  logic             mem_done_in,
  input  logic [31:0]      mem_data_in,
  output logic             broadcast_signal_out,
  output logic [31:0]      result_out,
  output logic [TAG_W-1:0] dest_tag_out
);

  localparam int PTR_W = $clog2(LSB_CAPACITY);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(LSB_CAPACITY);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  logic [CNT_W-1:0]        head, tail, count, keep_cnt;
  logic [PTR_W-1:0]        head_idx, tail_idx;
  logic [LSB_CAPACITY-1:0] valid, is_store, committed, keep;
  logic [2:0]              funct3 [LSB_CAPACITY];
  logic [TAG_W-1:0]        qj [LSB_CAPACITY];
  logic [TAG_W-1:0]        qk [LSB_CAPACITY];
  logic [TAG_W-1:0]        tag [LSB_CAPACITY];
  logic [31:0]             vj [LSB_CAPACITY];
  logic [31:0]             vk [LSB_CAPACITY];
  logic [31:0]             imm [LSB_CAPACITY];

  logic [0:0]       state, next_state;
  logic             killed, next_killed;
  logic             head_ready, start, done_now, kill_now, pop, push;
  logic [TAG_W-1:0] issue_qj, issue_qk;
  logic [31:0]      issue_vj, issue_vk, load_ext;
  logic [2:0]       req_funct3, nxt_funct3;
  logic [TAG_W-1:0] req_tag, nxt_req_tag, nxt_tag;
  logic             nxt_req, nxt_we, nxt_bcast;
  logic [31:0]      nxt_addr, nxt_data, nxt_result;
  logic [1:0]       nxt_size;

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CAP - 1'b1) ? '0 : p + 1'b1;
  endfunction

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign full_out = (count == CAP);

  assign head_ready = valid[head_idx] && (qj[head_idx] == '0) &&
                      (!is_store[head_idx] || ((qk[head_idx] == '0) && committed[head_idx]));
  assign start    = (state == IDLE) && (count != '0) && head_ready && !rollback_in;
  assign done_now = (state == WAIT_MEM) && mem_done_in;
  // A load whose entry was flushed still has to drain its access, silently.
  assign kill_now = killed || (rollback_in && !mem_we_out);
  assign pop      = done_now && !kill_now;
  assign push     = dec_issue_in && !rollback_in && (!full_out || pop);

  // Issue-time bypass of a broadcast arriving in the same cycle; ALU has priority.
  always_comb begin
    issue_qj = dec_Qj_in;
    issue_vj = dec_Vj_in;
    issue_qk = dec_Qk_in;
    issue_vk = dec_Vk_in;
    if (dec_Qj_in != '0) begin
      if (alu_broadcast_signal_in && alu_dest_tag_in == dec_Qj_in) begin
        issue_qj = '0;
        issue_vj = alu_result_in;
      end else if (rob_broadcast_signal_in && rob_dest_tag_in == dec_Qj_in) begin
        issue_qj = '0;
        issue_vj = rob_result_in;
      end
    end
    if (dec_Qk_in != '0) begin
      if (alu_broadcast_signal_in && alu_dest_tag_in == dec_Qk_in) begin
        issue_qk = '0;
        issue_vk = alu_result_in;
      end else if (rob_broadcast_signal_in && rob_dest_tag_in == dec_Qk_in) begin
        issue_qk = '0;
        issue_vk = rob_result_in;
      end
    end
  end

  // Entries surviving a rollback: the contiguous committed run starting at head.
  always_comb begin
    logic             run;
    logic [PTR_W-1:0] idx;
    keep     = '0;
    keep_cnt = '0;
    run      = 1'b1;
    for (int k = 0; k < LSB_CAPACITY; k++) begin
      idx = head_idx + PTR_W'(k);
      if (run && (CNT_W'(k) < count) && valid[idx] && committed[idx]) begin
        keep[idx] = 1'b1;
        keep_cnt  = keep_cnt + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      valid     <= '0;
      committed <= '0;
    end else begin
      for (int i = 0; i < LSB_CAPACITY; i++) begin
        if (valid[i] && qj[i] != '0) begin
          if (alu_broadcast_signal_in && alu_dest_tag_in == qj[i]) begin
            qj[i] <= '0;
            vj[i] <= alu_result_in;
          end else if (rob_broadcast_signal_in && rob_dest_tag_in == qj[i]) begin
            qj[i] <= '0;
            vj[i] <= rob_result_in;
          end
        end
        if (valid[i] && qk[i] != '0) begin
          if (alu_broadcast_signal_in && alu_dest_tag_in == qk[i]) begin
            qk[i] <= '0;
            vk[i] <= alu_result_in;
          end else if (rob_broadcast_signal_in && rob_dest_tag_in == qk[i]) begin
            qk[i] <= '0;
            vk[i] <= rob_result_in;
          end
        end
        if (commit_lsb_signal_in && !rollback_in && valid[i] && is_store[i] &&
            tag[i] == commit_tag_in)
          committed[i] <= 1'b1;
        if (rollback_in && !keep[i])
          valid[i] <= 1'b0;
      end
      if (pop)
        valid[head_idx] <= 1'b0;
      head <= pop ? ptr_inc(head) : head;
      if (rollback_in) begin
        tail  <= {1'b0, head_idx + keep_cnt[PTR_W-1:0]};
        count <= keep_cnt - CNT_W'(pop);
      end else begin
        tail  <= push ? ptr_inc(tail) : tail;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      if (push) begin
        valid[tail_idx]     <= 1'b1;
        committed[tail_idx] <= 1'b0;
        is_store[tail_idx]  <= dec_is_store_in;
        funct3[tail_idx]    <= dec_funct3_in;
        qj[tail_idx]        <= issue_qj;
        qk[tail_idx]        <= issue_qk;
        vj[tail_idx]        <= issue_vj;
        vk[tail_idx]        <= issue_vk;
        imm[tail_idx]       <= dec_imm_in;
        tag[tail_idx]       <= dec_dest_tag_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      killed               <= 1'b0;
      mem_req_out          <= 1'b0;
      mem_we_out           <= 1'b0;
      mem_addr_out         <= '0;
      mem_data_out         <= '0;
      mem_size_out         <= '0;
      broadcast_signal_out <= 1'b0;
      result_out           <= '0;
      dest_tag_out         <= '0;
      req_funct3           <= '0;
      req_tag              <= '0;
    end else begin
      state                <= next_state;
      killed               <= next_killed;
      mem_req_out          <= nxt_req;
      mem_we_out           <= nxt_we;
      mem_addr_out         <= nxt_addr;
      mem_data_out         <= nxt_data;
      mem_size_out         <= nxt_size;
      broadcast_signal_out <= nxt_bcast;
      result_out           <= nxt_result;
      dest_tag_out         <= nxt_tag;
      req_funct3           <= nxt_funct3;
      req_tag              <= nxt_req_tag;
    end
  end

  always_comb begin
    next_state  = state;
    next_killed = killed;
    case (state)
      IDLE:     if (start) next_state = WAIT_MEM;
      WAIT_MEM: if (mem_done_in) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (done_now)
      next_killed = 1'b0;
    else if (state == WAIT_MEM && rollback_in && !mem_we_out)
      next_killed = 1'b1;
  end

  always_comb begin
    case (req_funct3)
      3'b000:  load_ext = {{24{mem_data_in[7]}}, mem_data_in[7:0]};
      3'b001:  load_ext = {{16{mem_data_in[15]}}, mem_data_in[15:0]};
      3'b100:  load_ext = {24'd0, mem_data_in[7:0]};
      3'b101:  load_ext = {16'd0, mem_data_in[15:0]};
      default: load_ext = mem_data_in;
    endcase
  end

  always_comb begin
    nxt_req     = mem_req_out;
    nxt_we      = mem_we_out;
    nxt_addr    = mem_addr_out;
    nxt_data    = mem_data_out;
    nxt_size    = mem_size_out;
    nxt_bcast   = 1'b0;
    nxt_result  = result_out;
    nxt_tag     = dest_tag_out;
    nxt_funct3  = req_funct3;
    nxt_req_tag = req_tag;
    if (start) begin
      nxt_req     = 1'b1;
      nxt_we      = is_store[head_idx];
      nxt_addr    = vj[head_idx] + imm[head_idx];
      nxt_data    = vk[head_idx];
      nxt_size    = funct3[head_idx][1:0];
      nxt_funct3  = funct3[head_idx];
      nxt_req_tag = tag[head_idx];
    end
    if (done_now) begin
      nxt_req = 1'b0;
      if (!mem_we_out && !kill_now) begin
        nxt_bcast  = 1'b1;
        nxt_result = load_ext;
        nxt_tag    = req_tag;
      end
    end
  end

endmodule

`default_nettype wire
